// File: rtl/sensor_reg_ctrl_pkg.sv
// Shared register map, control/status bit positions and sampler state encoding
// for the sensor register controller.
package sensor_reg_ctrl_pkg;

  localparam logic [7:0] ADDR_ID     = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h01;
  localparam logic [7:0] ADDR_PERIOD = 8'h02;
  localparam logic [7:0] ADDR_STATUS = 8'h03;
  localparam logic [7:0] ADDR_COUNT  = 8'h04;
  localparam logic [7:0] ADDR_DATA   = 8'h05;
  localparam logic [7:0] ADDR_THRESH = 8'h06;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2
  } sampler_state_e;

  // Occupancy is reported as one byte, so deeper FIFOs clip at 255.
  function automatic logic [7:0] satByte(input logic [8:0] value);
    return (value > 9'd255) ? 8'hFF : value[7:0];
  endfunction

endpackage

// File: rtl/sensor_fifo.sv
// Synchronous sample FIFO with push, pop and flush; power-of-two depth so the
// pointers wrap on their own.
module sensor_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/sensor_reg_ctrl.sv
// I2C register map, periodic sample sequencer and sample FIFO front end.
// Optional THRESH register and FIFO threshold interrupt: define SENSOR_IRQ_EN.
module sensor_reg_ctrl
  import sensor_reg_ctrl_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter int         PRESCALE   = 256,
  parameter logic [7:0] CHIP_ID    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       write_en,
  output logic [7:0] rd_data,
  input  logic       fifo_rd_en,
  output logic       smp_req,
  input  logic       smp_valid,
  input  logic [7:0] smp_data,
  output logic       irq
);

  localparam int PW = $clog2(PRESCALE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sampler_state_e state_q;
  logic [PW-1:0]  prescaleCnt_q;
  logic [7:0]     tickCnt_q;
  logic           smpReq_q;
  logic           en_q;
  logic           en_d;
  logic [7:0]     period_q;
  logic           ovf_q;
  logic [7:0]     rdData_q;
  logic [7:0]     rdData_d;
  logic           writeCtrl;
  logic           flush;
  logic           push;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [7:0]     fifoHead;
  logic [CW-1:0]  fifoCount;
  logic [7:0]     countByte;
  logic [7:0]     statusByte;

  assign writeCtrl = write_en && (reg_addr == ADDR_CTRL);
  assign en_d      = writeCtrl ? wr_data[CTRL_EN_BIT] : en_q;
  assign flush     = writeCtrl && wr_data[CTRL_FLUSH_BIT];
  assign push      = smpReq_q && smp_valid;
  assign countByte = satByte(9'(fifoCount));

  sensor_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (fifo_rd_en),
    .flush_i (flush),
    .data_i  (smp_data),
    .head_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // OVF set wins over a same-cycle clear so no overflow event is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= 1'b0;
      period_q <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      en_q <= en_d;
      if (write_en && (reg_addr == ADDR_PERIOD)) period_q <= wr_data;
      if (push && fifoFull && !fifo_rd_en) begin
        ovf_q <= 1'b1;
      end else if (write_en && (reg_addr == ADDR_STATUS) && wr_data[STAT_OVF_BIT]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // The sequencer follows the incoming EN value, so a disabling write also
  // takes smp_req down at that edge while still accepting a coincident sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      prescaleCnt_q <= '0;
      tickCnt_q     <= 8'h00;
      smpReq_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_d) begin
            state_q       <= S_WAIT;
            prescaleCnt_q <= '0;
            tickCnt_q     <= 8'h00;
          end
        end
        S_WAIT: begin
          if (!en_d) begin
            state_q <= S_IDLE;
          end else if (prescaleCnt_q == PW'(PRESCALE - 1)) begin
            prescaleCnt_q <= '0;
            if (tickCnt_q >= period_q) begin
              state_q   <= S_REQ;
              smpReq_q  <= 1'b1;
              tickCnt_q <= 8'h00;
            end else begin
              tickCnt_q <= tickCnt_q + 8'd1;
            end
          end else begin
            prescaleCnt_q <= prescaleCnt_q + 1'b1;
          end
        end
        S_REQ: begin
          if (!en_d) begin
            state_q  <= S_IDLE;
            smpReq_q <= 1'b0;
          end else if (smp_valid) begin
            state_q       <= S_WAIT;
            smpReq_q      <= 1'b0;
            prescaleCnt_q <= '0;
            tickCnt_q     <= 8'h00;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          smpReq_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    statusByte                 = 8'h00;
    statusByte[STAT_EMPTY_BIT] = fifoEmpty;
    statusByte[STAT_FULL_BIT]  = fifoFull;
    statusByte[STAT_OVF_BIT]   = ovf_q;
  end

`ifdef SENSOR_IRQ_EN
  logic [7:0] thresh_q;
  logic       irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thresh_q <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      if (write_en && (reg_addr == ADDR_THRESH)) thresh_q <= wr_data;
      irq_q <= (thresh_q != 8'h00) && (countByte >= thresh_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdData_d = 8'h00;
    case (reg_addr)
      ADDR_ID:     rdData_d = CHIP_ID;
      ADDR_CTRL:   rdData_d = {7'd0, en_q};
      ADDR_PERIOD: rdData_d = period_q;
      ADDR_STATUS: rdData_d = statusByte;
      ADDR_COUNT:  rdData_d = countByte;
      ADDR_DATA:   rdData_d = fifoEmpty ? 8'h00 : fifoHead;
`ifdef SENSOR_IRQ_EN
      ADDR_THRESH: rdData_d = thresh_q;
`else
      ADDR_THRESH: rdData_d = 8'h00;
`endif
      default:     rdData_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdData_q <= 8'h00;
    else      rdData_q <= rdData_d;
  end

  assign rd_data = rdData_q;
  assign smp_req = smpReq_q;

endmodule

// File: tb/tb_sensor_reg_ctrl.sv
// Directed bench for sensor_reg_ctrl: register-map vector table followed by
// hand-written sampler and FIFO corner sequences.
module tb_sensor_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       write_en = 1'b0;
  logic [7:0] rd_data;
  logic       fifo_rd_en = 1'b0;
  logic       smp_req;
  logic       smp_valid = 1'b0;
  logic [7:0] smp_data = 8'h00;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       isWrite;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] expRd;
  } vec_t;

  vec_t vecs[17];

  sensor_reg_ctrl #(
    .FIFO_DEPTH (16),
    .PRESCALE   (4),
    .CHIP_ID    (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_addr   (reg_addr),
    .wr_data    (wr_data),
    .write_en   (write_en),
    .rd_data    (rd_data),
    .fifo_rd_en (fifo_rd_en),
    .smp_req    (smp_req),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Every step lands 1 time unit after a rising edge, away from the edge itself.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
    end
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [7:0] data);
    reg_addr = addr;
    wr_data  = data;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [7:0] addr, input logic [7:0] expected);
    reg_addr = addr;
    tick();
    checkOutput(name, rd_data, expected);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    if (v.isWrite) writeReg(v.addr, v.data);
    else readCheck($sformatf("vec%0d_rd%02h", idx, v.addr), v.addr, v.expRd);
  endtask

  task automatic waitReq(input string name);
    int n = 0;
    while (!smp_req && n < 60) begin
      tick();
      n++;
    end
    checkOutput(name, {7'd0, smp_req}, 8'd1);
  endtask

  task automatic serviceSample(input logic [7:0] data, input logic pop);
    waitReq("waitReq");
    smp_valid  = 1'b1;
    smp_data   = data;
    fifo_rd_en = pop;
    tick();
    smp_valid  = 1'b0;
    fifo_rd_en = 1'b0;
  endtask

  initial begin
    int k;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'hA5};
    vecs[1]  = '{1'b0, 8'h03, 8'h00, 8'h01};
    vecs[2]  = '{1'b0, 8'h04, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 8'h05, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 8'h01, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 8'h02, 8'h5A, 8'h00};
    vecs[6]  = '{1'b0, 8'h02, 8'h00, 8'h5A};
    vecs[7]  = '{1'b1, 8'h01, 8'hFE, 8'h00};
    vecs[8]  = '{1'b0, 8'h01, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 8'h07, 8'hFF, 8'h00};
    vecs[10] = '{1'b0, 8'h07, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 8'h06, 8'h00, 8'h00};
    vecs[12] = '{1'b1, 8'h03, 8'h07, 8'h00};
    vecs[13] = '{1'b0, 8'h03, 8'h00, 8'h01};
    vecs[14] = '{1'b1, 8'h02, 8'h02, 8'h00};
    vecs[15] = '{1'b0, 8'h02, 8'h00, 8'h02};
    vecs[16] = '{1'b0, 8'hFF, 8'h00, 8'h00};

    // Outputs while reset is held
    #3;
    checkOutput("rstRdData", rd_data, 8'h00);
    checkOutput("rstSmpReq", {7'd0, smp_req}, 8'h00);
    checkOutput("rstIrq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) applyStimulus(i, vecs[i]);

    // PERIOD=2, PRESCALE=4: request 12 cycles after the enabling write
    writeReg(8'h01, 8'h01);
    checkOutput("reqLowAfterEn", {7'd0, smp_req}, 8'h00);
    k = 0;
    while (!smp_req && k < 40) begin
      tick();
      k++;
    end
    checkOutput("reqLatency", 8'(k), 8'd12);
    smp_valid = 1'b1;
    smp_data  = 8'h3C;
    tick();
    smp_valid = 1'b0;
    checkOutput("reqDropAfterValid", {7'd0, smp_req}, 8'h00);
    readCheck("countOne", 8'h04, 8'h01);
    readCheck("dataFirst", 8'h05, 8'h3C);

    // Fill to 16, then overflow
    writeReg(8'h02, 8'h00);
    for (int i = 1; i <= 15; i++) serviceSample(8'(i), 1'b0);
    readCheck("countFull", 8'h04, 8'h10);
    readCheck("statusFull", 8'h03, 8'h02);
    serviceSample(8'hEE, 1'b0);
    readCheck("countOvf", 8'h04, 8'h10);
    readCheck("statusOvf", 8'h03, 8'h06);
    writeReg(8'h03, 8'h04);
    readCheck("statusOvfClr", 8'h03, 8'h02);
    readCheck("headAfterOvf", 8'h05, 8'h3C);

    // Flush, then pop on empty
    writeReg(8'h01, 8'h03);
    readCheck("countFlush", 8'h04, 8'h00);
    readCheck("statusFlush", 8'h03, 8'h01);
    readCheck("ctrlAfterFlush", 8'h01, 8'h01);
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    readCheck("countPopEmpty", 8'h04, 8'h00);
    readCheck("statusPopEmpty", 8'h03, 8'h01);
    readCheck("dataEmpty", 8'h05, 8'h00);

    // Push and pop together on an empty FIFO: push only
    serviceSample(8'h77, 1'b1);
    readCheck("countPushPopEmpty", 8'h04, 8'h01);
    readCheck("dataPushPopEmpty", 8'h05, 8'h77);
    writeReg(8'h01, 8'h03);

    // Push and pop together at COUNT=5
    for (int i = 0; i < 5; i++) serviceSample(8'h10 + 8'(i), 1'b0);
    readCheck("countFive", 8'h04, 8'h05);
    readCheck("headFive", 8'h05, 8'h10);
    serviceSample(8'h15, 1'b1);
    readCheck("countPushPop", 8'h04, 8'h05);
    readCheck("headPushPop", 8'h05, 8'h11);
    reg_addr   = 8'h05;
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    checkOutput("headAtPop", rd_data, 8'h11);
    tick();
    checkOutput("headAfterPop", rd_data, 8'h12);

    // Clearing EN while requesting: no push
    waitReq("waitReqDisable");
    writeReg(8'h01, 8'h00);
    checkOutput("reqOffAfterDisable", {7'd0, smp_req}, 8'h00);
    smp_valid = 1'b1;
    smp_data  = 8'h99;
    tick();
    smp_valid = 1'b0;
    checkOutput("reqStaysOff", {7'd0, smp_req}, 8'h00);
    readCheck("countNoPush", 8'h04, 8'h04);

    // Sample coincident with the disabling write is still taken
    writeReg(8'h01, 8'h01);
    waitReq("waitReqCoincident");
    smp_valid = 1'b1;
    smp_data  = 8'h5E;
    writeReg(8'h01, 8'h00);
    smp_valid = 1'b0;
    checkOutput("reqOffCoincident", {7'd0, smp_req}, 8'h00);
    readCheck("countCoincident", 8'h04, 8'h05);

    // Threshold interrupt
    writeReg(8'h01, 8'h03);
    writeReg(8'h06, 8'h03);
`ifdef SENSOR_IRQ_EN
    readCheck("threshRead", 8'h06, 8'h03);
`else
    readCheck("threshRead", 8'h06, 8'h00);
`endif
    serviceSample(8'hA1, 1'b0);
    serviceSample(8'hA2, 1'b0);
    serviceSample(8'hA3, 1'b0);
    checkOutput("irqAtCount3", {7'd0, irq}, 8'h00);
    tick();
`ifdef SENSOR_IRQ_EN
    checkOutput("irqRise", {7'd0, irq}, 8'h01);
`else
    checkOutput("irqTiedLow", {7'd0, irq}, 8'h00);
`endif
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
`ifdef SENSOR_IRQ_EN
    checkOutput("irqHoldAtPop", {7'd0, irq}, 8'h01);
`endif
    tick();
    checkOutput("irqAfterPop", {7'd0, irq}, 8'h00);

    // Asynchronous reset while requesting
    waitReq("waitReqReset");
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncRstSmpReq", {7'd0, smp_req}, 8'h00);
    checkOutput("asyncRstRdData", rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    tick();
    readCheck("ctrlAfterRst", 8'h01, 8'h00);
    readCheck("countAfterRst", 8'h04, 8'h00);
    readCheck("periodAfterRst", 8'h02, 8'h00);
    readCheck("statusAfterRst", 8'h03, 8'h01);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("idleAfterRst", {7'd0, smp_req}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
